pow_5_seq_feeder: RTL and testbench

Upstream feeder and result collector for the sequential (multi-cycle) fifth-power engine. Buffers incoming operands in a small FIFO and launches each one into the engine with a one-cycle `run` pulse once the engine is idle. Pairs each returned result with its original operand and presents the pair downstream as a one-cycle valid strobe. Lets a producer stream operands back-to-back without tracking the engine's `ready` protocol itself.

---
 rtl/pow_5_seq_feeder.sv | 126 ++++++++++++
 tb/tb_pow_5_seq_feeder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_5_seq_feeder.sv
// pow_5_seq_feeder: buffers producer operands in a small FIFO, launches each
// one into the sequential fifth-power engine once it is idle, and returns the
// engine result paired with the operand that produced it.
module pow_5_seq_feeder #(
  parameter int WIDTH      = 18,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_n,
  output logic             in_ready,
  output logic             pow_run,
  output logic [WIDTH-1:0] pow_n,
  input  logic             pow_ready,
  input  logic [WIDTH-1:0] pow_result,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_n,
  output logic [WIDTH-1:0] out_pow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [WIDTH-1:0]      inflight_n;
  logic                  ready_q;
  logic                  push, pop, complete, ready_rise;

  // The FIFO accepts whenever it is not full; the decision uses the current
  // count only, so a simultaneous pop never frees a slot for this edge.
  assign in_ready   = (count != FULL_COUNT);
  assign push       = in_valid && in_ready;
  // Only a low-to-high transition of the engine flag counts as completion, so
  // an engine that is already ready when we launch is never mistaken as done.
  assign ready_rise = pow_ready && !ready_q;

  // Next-state and per-edge strobes: pop the head when idle with data,
  // finish when the engine flag rises while busy.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (ready_rise) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight operation and treats the
  // engine as idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_n;
  end

  // FIFO pointers wrap naturally at the power-of-two depth; a push and a pop
  // on the same edge move both pointers and leave the count unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered engine launch and result capture; run and valid are one-cycle
  // strobes because they are rewritten from the strobes on every edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pow_run    <= 1'b0;
      pow_n      <= '0;
      inflight_n <= '0;
      out_valid  <= 1'b0;
      out_n      <= '0;
      out_pow    <= '0;
      ready_q    <= 1'b0;
    end else begin
      ready_q   <= pow_ready;
      pow_run   <= pop;
      out_valid <= complete;
      if (pop) begin
        pow_n      <= mem[rd_ptr];
        inflight_n <= mem[rd_ptr];
      end
      if (complete) begin
        out_n   <= inflight_n;
        out_pow <= pow_result;
      end
    end
  end

endmodule

// File: tb/tb_pow_5_seq_feeder.sv
// tb_pow_5_seq_feeder: drives the feeder against a behavioural fifth-power
// engine with a three-cycle latency and checks launches and returned pairs.
module tb_pow_5_seq_feeder;

  localparam int WIDTH = 18;
  localparam int LAT   = 3;

  typedef struct {
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] pow;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_n = '0;
  logic             in_ready;
  logic             pow_run;
  logic [WIDTH-1:0] pow_n;
  logic             pow_ready;
  logic [WIDTH-1:0] pow_result;
  logic             out_valid;
  logic [WIDTH-1:0] out_n;
  logic [WIDTH-1:0] out_pow;

  logic             eng_ready, eng_busy, hold = 1'b0, pulse_low = 1'b0;
  int               eng_cnt;
  logic [WIDTH-1:0] eng_n;

  logic [WIDTH-1:0] out_n_q[$];
  logic [WIDTH-1:0] out_pow_q[$];
  int               run_count = 0, run_double = 0, ov_double = 0;
  logic             prev_ov = 1'b0, prev_run = 1'b0;

  int tests = 0;
  int failures = 0;

  vec_t table_v [11];

  pow_5_seq_feeder #(.WIDTH(WIDTH), .DEPTH_LOG2(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_n       (in_n),
    .in_ready   (in_ready),
    .pow_run    (pow_run),
    .pow_n      (pow_n),
    .pow_ready  (pow_ready),
    .pow_result (pow_result),
    .out_valid  (out_valid),
    .out_n      (out_n),
    .out_pow    (out_pow)
  );

  // Free-running clock, 10 ns period.
  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] pow5(input logic [WIDTH-1:0] n);
    logic [63:0] x;
    x = 64'(n);
    return WIDTH'(x * x * x * x * x);
  endfunction

  // Behavioural engine: drops ready on launch, raises it LAT edges later
  // unless held; pulse_low lets the bench fake a ready glitch while idle.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eng_ready  <= 1'b1;
      eng_busy   <= 1'b0;
      eng_cnt    <= 0;
      eng_n      <= '0;
      pow_result <= '0;
    end else if (pow_run) begin
      eng_ready <= 1'b0;
      eng_busy  <= 1'b1;
      eng_cnt   <= LAT;
      eng_n     <= pow_n;
    end else if (eng_busy && !hold) begin
      if (eng_cnt == 1) begin
        eng_ready  <= 1'b1;
        eng_busy   <= 1'b0;
        pow_result <= pow5(eng_n);
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  assign pow_ready = eng_ready && !pulse_low;

  // Output monitor on the falling edge: collects returned pairs and counts
  // launch pulses, flagging any strobe wider than one cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid) begin
        out_n_q.push_back(out_n);
        out_pow_q.push_back(out_pow);
        if (prev_ov) ov_double++;
      end
      if (pow_run) begin
        if (prev_run) run_double++;
        else          run_count++;
      end
      prev_ov  = out_valid;
      prev_run = pow_run;
    end else begin
      prev_ov  = 1'b0;
      prev_run = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Push one operand, waiting (bounded) for space in the FIFO.
  task automatic applyStimulus(input logic [WIDTH-1:0] n);
    int guard;
    guard = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_n     = n;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) checkOutput("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitOutputs(input string name, input int k, input int budget);
    int guard;
    guard = 0;
    while (out_n_q.size() < k && guard < budget) begin
      @(negedge clock);
      guard++;
    end
    checkOutput(name, 32'(out_n_q.size()), 32'(k));
  endtask

  task automatic clearQueues();
    out_n_q.delete();
    out_pow_q.delete();
  endtask

  initial begin
    int guard, found9, runs0;

    table_v[0]  = '{n: 18'd0,  pow: 18'd0};
    table_v[1]  = '{n: 18'd1,  pow: 18'd1};
    table_v[2]  = '{n: 18'd2,  pow: 18'd32};
    table_v[3]  = '{n: 18'd3,  pow: 18'd243};
    table_v[4]  = '{n: 18'd4,  pow: 18'd1024};
    table_v[5]  = '{n: 18'd5,  pow: 18'd3125};
    table_v[6]  = '{n: 18'd6,  pow: 18'd7776};
    table_v[7]  = '{n: 18'd7,  pow: 18'd16807};
    table_v[8]  = '{n: 18'd8,  pow: 18'd32768};
    table_v[9]  = '{n: 18'd9,  pow: 18'd59049};
    table_v[10] = '{n: 18'd13, pow: 18'd109149};

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_pow_run",   32'(pow_run),   32'd0);
    checkOutput("rst_pow_n",     32'(pow_n),     32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_n",     32'(out_n),     32'd0);
    checkOutput("rst_out_pow",   32'(out_pow),   32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single operand with launch timing
    clearQueues();
    applyStimulus(18'd3);
    @(negedge clock);
    checkOutput("single_no_bypass", 32'(pow_run), 32'd0);
    @(negedge clock);
    checkOutput("single_run",   32'(pow_run), 32'd1);
    checkOutput("single_pow_n", 32'(pow_n),   32'd3);
    @(negedge clock);
    checkOutput("single_run_low", 32'(pow_run), 32'd0);
    waitOutputs("single_count", 1, 50);
    if (out_n_q.size() >= 1) begin
      checkOutput("single_out_n",   32'(out_n_q[0]),   32'd3);
      checkOutput("single_out_pow", 32'(out_pow_q[0]), 32'd243);
    end
    checkOutput("single_runs", 32'(run_count), 32'd1);

    // Back-to-back burst keeps order
    clearQueues();
    applyStimulus(18'd1);
    applyStimulus(18'd2);
    applyStimulus(18'd7);
    applyStimulus(18'd12);
    waitOutputs("burst_count", 4, 100);
    if (out_n_q.size() >= 4) begin
      checkOutput("burst_n0",   32'(out_n_q[0]),   32'd1);
      checkOutput("burst_pow0", 32'(out_pow_q[0]), 32'd1);
      checkOutput("burst_n1",   32'(out_n_q[1]),   32'd2);
      checkOutput("burst_pow1", 32'(out_pow_q[1]), 32'd32);
      checkOutput("burst_n2",   32'(out_n_q[2]),   32'd7);
      checkOutput("burst_pow2", 32'(out_pow_q[2]), 32'd16807);
      checkOutput("burst_n3",   32'(out_n_q[3]),   32'd12);
      checkOutput("burst_pow3", 32'(out_pow_q[3]), 32'd248832);
    end

    // Full FIFO with the engine stalled: 20 in flight, 21..24 buffered
    clearQueues();
    hold = 1'b1;
    for (int i = 20; i <= 24; i++) applyStimulus(WIDTH'(i));
    @(negedge clock);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_n     = 18'd9;
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    checkOutput("full_still_full", 32'(in_ready), 32'd0);
    hold  = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("full_first_done", 32'(out_valid), 32'd1);
    checkOutput("full_ready_at_done", 32'(in_ready), 32'd0);
    @(negedge clock);
    checkOutput("full_ready_after_pop", 32'(in_ready), 32'd1);
    waitOutputs("full_count", 5, 200);
    found9 = 0;
    foreach (out_n_q[i]) if (out_n_q[i] == 18'd9) found9++;
    checkOutput("full_dropped_9", 32'(found9), 32'd0);
    for (int i = 0; i < 5 && i < out_n_q.size(); i++) begin
      checkOutput("full_order_n",   32'(out_n_q[i]),   32'(20 + i));
      checkOutput("full_order_pow", 32'(out_pow_q[i]), 32'(pow5(WIDTH'(20 + i))));
    end

    // Table-driven stream through the FIFO, wrapping the pointers
    clearQueues();
    for (int i = 0; i < 11; i++) applyStimulus(table_v[i].n);
    waitOutputs("wrap_count", 11, 400);
    for (int i = 0; i < 11 && i < out_n_q.size(); i++) begin
      checkOutput($sformatf("wrap_n%0d", i),   32'(out_n_q[i]),   32'(table_v[i].n));
      checkOutput($sformatf("wrap_pow%0d", i), 32'(out_pow_q[i]), 32'(table_v[i].pow));
    end
    checkOutput("no_wide_out_valid", 32'(ov_double),  32'd0);
    checkOutput("no_wide_pow_run",   32'(run_double), 32'd0);

    // Reset while busy with two operands queued
    clearQueues();
    hold = 1'b1;
    applyStimulus(18'd30);
    applyStimulus(18'd31);
    applyStimulus(18'd32);
    repeat (3) @(negedge clock);
    checkOutput("midrst_pre_pow_n", 32'(pow_n), 32'd30);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_pow_n",     32'(pow_n),     32'd0);
    checkOutput("midrst_out_n",     32'(out_n),     32'd0);
    checkOutput("midrst_out_pow",   32'(out_pow),   32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready",  32'(in_ready),  32'd1);
    hold = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    runs0 = run_count;
    repeat (20) @(negedge clock);
    checkOutput("midrst_no_stale_out", 32'(out_n_q.size()), 32'd0);
    checkOutput("midrst_no_launch",    32'(run_count),      32'(runs0));
    applyStimulus(18'd5);
    waitOutputs("midrst_count", 1, 50);
    if (out_n_q.size() >= 1) begin
      checkOutput("midrst_out_n5",   32'(out_n_q[0]),   32'd5);
      checkOutput("midrst_out_pow5", 32'(out_pow_q[0]), 32'd3125);
    end

    // Ready high (and a ready glitch) while idle produces nothing
    clearQueues();
    runs0 = run_count;
    repeat (10) @(negedge clock);
    pulse_low = 1'b1;
    repeat (2) @(negedge clock);
    pulse_low = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("idle_no_out",    32'(out_n_q.size()), 32'd0);
    checkOutput("idle_no_launch", 32'(run_count),      32'(runs0));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
